// File: rtl/rr_prio_arbiter_8_if.sv
// Purpose: request/grant bundle between eight requesters and the shared-resource arbiter.
// Latency: none; this is wiring only.
// Backpressure: none here; the arbiter holds the grant until done, a dropped request, or timeout.
//
// Signals:
//   req_in        requester -> arbiter  per-requester request bits
//   rr_en         requester -> arbiter  1 = round-robin, 0 = fixed priority
//   done          requester -> arbiter  current owner releases the resource
//   gnt_valid     arbiter -> requester  a grant is active
//   gnt_idx       arbiter -> requester  encoded owner index (0 when idle)
//   gnt_onehot    arbiter -> requester  one-hot owner (0 when idle)
//   timeout_pulse arbiter -> requester  one-cycle flag after a forced release
interface rr_prio_arbiter_8_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
);
    logic [N_REQ-1:0] req_in;
    logic             rr_en;
    logic             done;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_onehot;
    logic             timeout_pulse;

    modport master (
        output req_in, rr_en, done,
        input  gnt_valid, gnt_idx, gnt_onehot, timeout_pulse
    );

    modport slave (
        input  req_in, rr_en, done,
        output gnt_valid, gnt_idx, gnt_onehot, timeout_pulse
    );
endinterface

// File: rtl/rr_prio_arbiter_8.sv
// Purpose: shares one resource among 8 requesters; fixed (MSB-first) or round-robin selection.
// Latency: request sampled at edge t, registered grant visible after edge t.
// Backpressure: grant held until done, owner drops its request, or MAX_HOLD cycles elapse.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   arb    slave side of rr_prio_arbiter_8_if (requests in, registered grant out)
//
// MAX_HOLD is only meaningful in 2..255; the 8-bit hold counter cannot wrap in that range.
module rr_prio_arbiter_8 #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_prio_arbiter_8_if.slave  arb
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_q, state_nxt;
    logic [IDX_W-1:0] last_idx_q, last_idx_nxt;
    logic [7:0]       hold_cnt_q, hold_cnt_nxt;
    logic             gnt_valid_q, gnt_valid_nxt;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_nxt;
    logic [N_REQ-1:0] gnt_onehot_q, gnt_onehot_nxt;
    logic             timeout_q, timeout_nxt;

    // Winner search
    logic [IDX_W-1:0] search_base;
    logic [IDX_W-1:0] cand;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;

    // Candidates are visited base-1, base-2, ... base (mod 8), so base itself
    // is the lowest priority. Fixed mode uses base 0, which yields 7..0 and
    // makes highest-index-wins fall out of the same search.
    always_comb begin
        search_base = arb.rr_en ? last_idx_q : '0;
        cand        = '0;
        win_found   = 1'b0;
        win_idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = search_base - IDX_W'(k);
            if (!win_found && arb.req_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_idx_q   <= '0;
            hold_cnt_q   <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            last_idx_q   <= last_idx_nxt;
            hold_cnt_q   <= hold_cnt_nxt;
            gnt_valid_q  <= gnt_valid_nxt;
            gnt_idx_q    <= gnt_idx_nxt;
            gnt_onehot_q <= gnt_onehot_nxt;
            timeout_q    <= timeout_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state_q;
        last_idx_nxt   = last_idx_q;
        hold_cnt_nxt   = hold_cnt_q;
        gnt_valid_nxt  = gnt_valid_q;
        gnt_idx_nxt    = gnt_idx_q;
        gnt_onehot_nxt = gnt_onehot_q;
        timeout_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                // done is deliberately ignored while nobody owns the resource.
                if (win_found) begin
                    state_nxt      = OWN;
                    gnt_valid_nxt  = 1'b1;
                    gnt_idx_nxt    = win_idx;
                    gnt_onehot_nxt = N_REQ'(1) << win_idx;
                    last_idx_nxt   = win_idx;
                    hold_cnt_nxt   = '0;
                end
            end

            OWN: begin
                // Normal release is checked first so done beats a coincident timeout.
                if (arb.done || !arb.req_in[gnt_idx_q]) begin
                    state_nxt      = IDLE;
                    gnt_valid_nxt  = 1'b0;
                    gnt_idx_nxt    = '0;
                    gnt_onehot_nxt = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    // hold_cnt is 0 on the first owned cycle, so this edge ends
                    // exactly MAX_HOLD visible grant cycles.
                    state_nxt      = IDLE;
                    gnt_valid_nxt  = 1'b0;
                    gnt_idx_nxt    = '0;
                    gnt_onehot_nxt = '0;
                    timeout_nxt    = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign arb.gnt_valid     = gnt_valid_q;
    assign arb.gnt_idx       = gnt_idx_q;
    assign arb.gnt_onehot    = gnt_onehot_q;
    assign arb.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_rr_prio_arbiter_8.sv
// Purpose: directed self-checking bench for rr_prio_arbiter_8 (table vectors plus timeout/reset sequences).
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 time unit after the next one.
// Backpressure: not applicable; the bench drives done/req_in directly.
module tb_rr_prio_arbiter_8;

    logic clk;
    logic rst_n;

    rr_prio_arbiter_8_if #(.N_REQ(8), .IDX_W(3)) bus ();

    rr_prio_arbiter_8 #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rr;
        logic       done;
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
        logic       to;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [7:0] req, input logic rr, input logic done,
                                input logic v, input logic [2:0] idx, input logic to);
        vec_t r;
        r.req  = req;
        r.rr   = rr;
        r.done = done;
        r.v    = v;
        r.idx  = idx;
        r.oh   = v ? (8'd1 << idx) : 8'd0;
        r.to   = to;
        return r;
    endfunction

    task automatic check(input string name, input logic v, input logic [2:0] idx,
                         input logic [7:0] oh, input logic to);
        logic [12:0] act;
        logic [12:0] exp;
        act = {bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout_pulse};
        exp = {v, idx, oh, to};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b idx=%0d onehot=%h timeout=%0b, expected valid=%0b idx=%0d onehot=%h timeout=%0b",
                     name, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout_pulse, v, idx, oh, to);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_seq[10] = '{0, 7, 6, 5, 4, 3, 2, 1, 0, 7};

        // Fixed priority, starting from reset (last_idx = 0).
        tbl.push_back(mk(8'b1100_1100, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0));
        tbl.push_back(mk(8'b1100_1100, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(8'b0001_0010, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0));
        tbl.push_back(mk(8'b0001_0010, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(8'b0000_0011, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0));
        tbl.push_back(mk(8'b0000_0011, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        // Round-robin with all requesting; last_idx=1 so 0 is next, then 7..0, 7.
        foreach (rr_seq[i]) begin
            tbl.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b1, 3'(rr_seq[i]), 1'b0));
            tbl.push_back(mk(8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
        end
        // Skip: from last_idx=7 with only 5 requesting -> 5; then 0, then 5 again.
        tbl.push_back(mk(8'b0010_0000, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0));
        tbl.push_back(mk(8'b0010_0000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(8'b0010_0001, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0));
        tbl.push_back(mk(8'b0010_0001, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(8'b0010_0001, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0));
        tbl.push_back(mk(8'b0010_0001, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
        // Owner 3 drops its request: release without timeout; done in IDLE ignored.
        tbl.push_back(mk(8'b0000_1000, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0));
        tbl.push_back(mk(8'b0000_0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(8'b0000_0000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));

        // Reset with everyone requesting.
        rst_n       = 1'b0;
        bus.req_in  = 8'hFF;
        bus.rr_en   = 1'b0;
        bus.done    = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", 1'b0, 3'd0, 8'h00, 1'b0);
        end
        bus.req_in = 8'h00;
        rst_n      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.done = i[0];
            tick();
            check("idle_no_req", 1'b0, 3'd0, 8'h00, 1'b0);
        end
        bus.done = 1'b0;

        foreach (tbl[i]) begin
            bus.req_in = tbl[i].req;
            bus.rr_en  = tbl[i].rr;
            bus.done   = tbl[i].done;
            tick();
            check($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].oh, tbl[i].to);
        end

        // Timeout: single request held with no done.
        bus.req_in = 8'h04;
        bus.rr_en  = 1'b0;
        bus.done   = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check($sformatf("to_hold_c%0d", c), 1'b1, 3'd2, 8'h04, 1'b0);
        end
        tick();
        check("to_pulse", 1'b0, 3'd0, 8'h00, 1'b1);
        tick();
        check("to_regrant", 1'b1, 3'd2, 8'h04, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            check($sformatf("done_hold_c%0d", c), 1'b1, 3'd2, 8'h04, 1'b0);
        end
        // done on the 16th cycle wins over the timeout.
        bus.done = 1'b1;
        tick();
        check("done_at_limit", 1'b0, 3'd0, 8'h00, 1'b0);
        bus.done   = 1'b0;
        bus.req_in = 8'h00;
        tick();
        check("done_at_limit_after", 1'b0, 3'd0, 8'h00, 1'b0);

        // Async reset mid-grant; last_idx=2 so round-robin picks 1 first.
        bus.req_in = 8'hFF;
        bus.rr_en  = 1'b1;
        tick();
        check("pre_reset_grant", 1'b1, 3'd1, 8'h02, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", 1'b0, 3'd0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_reset_grant", 1'b1, 3'd7, 8'h80, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
